// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit.
// One radix-2 step per cycle: shift-add multiply, restoring divide, both on operand
// magnitudes with a sign fix-up on the final step. *W ops run 32 steps on src[31:0]
// and sign-extend the 32-bit result. Divide-by-zero and signed overflow can finish
// without iterating (EARLY_OUT=1).
module mdu_iter #(
    parameter int XLEN      = 64,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int            CW        = $clog2(XLEN);
    localparam bit            HAS_WORD  = (XLEN == 64);
    localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(31);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Operation context latched on accept
    logic [2:0]      op_q;
    logic            word_q;
    logic            neg_q;       // final result (high product / quotient / remainder) is negative
    logic            spec_q;      // divide-by-zero or overflow: result is spec_res_q
    logic [XLEN-1:0] spec_res_q;

    // Iteration registers: {hi,lo} is the product or {remainder, dividend/quotient}
    logic [XLEN-1:0] hi, lo;
    logic [XLEN-1:0] opnd;        // multiplicand or divisor magnitude

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [XLEN-1:0] t;
        t = $signed(v);
        return t;
    endfunction

    logic            accept;
    logic            word_w, is_div, sgn1, sgn2, a_neg, b_neg, div0, ovf, special, neg_w;
    logic [XLEN-1:0] x1, x2, z1, z2, mag1, mag2, min_w, special_res, dvd_load;

    assign in_ready = (state == IDLE) && !reset && !flush;
    assign accept   = in_valid && in_ready;

    // Decode the incoming op: signedness, operand magnitudes and boundary cases
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        word_w = in_word && HAS_WORD;
        is_div = in_op[2];
        if (is_div) begin
            sgn1 = !in_op[0];
            sgn2 = !in_op[0];
        end else if (!word_w) begin
            sgn1 = (in_op == 3'd1) || (in_op == 3'd2);
            sgn2 = (in_op == 3'd1);
        end
        x1 = word_w ? sext32(in_src1[31:0]) : in_src1;
        x2 = word_w ? sext32(in_src2[31:0]) : in_src2;
        z1 = in_src1;
        z2 = in_src2;
        if (word_w) begin
            z1 = '0;
            z2 = '0;
            z1[31:0] = in_src1[31:0];
            z2[31:0] = in_src2[31:0];
        end
        a_neg = sgn1 && x1[XLEN-1];
        b_neg = sgn2 && x2[XLEN-1];
        mag1  = a_neg ? -x1 : z1;
        mag2  = b_neg ? -x2 : z2;
        // Word dividend sits at the top of lo so its MSB is shifted out first
        dvd_load = word_w ? (mag1 << (XLEN - 32)) : mag1;

        min_w = '0;
        min_w[XLEN-1] = 1'b1;
        if (word_w) min_w = sext32(32'h8000_0000);
        div0    = (x2 == '0);
        ovf     = is_div && !in_op[0] && (x1 == min_w) && (x2 == '1);
        special = is_div && (div0 || ovf);
        if (div0) special_res = in_op[1] ? x1 : '1;
        else      special_res = in_op[1] ? '0 : x1;
        neg_w = (is_div && in_op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge, last;
    logic [XLEN-1:0] hi_n, lo_n, mul_res, div_q, div_r, div_res, final_res;

    // One iteration step plus the sign fix-up applied on the last step
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        if (op_q[2]) begin
            hi_n = div_ge ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
        last = (cnt == (word_q ? LAST_WORD : LAST_FULL));

        // Word product lands at {hi,lo}[XLEN-32 +: 64]; its low half is lo's top 32 bits
        if (word_q)               mul_res = sext32(lo_n[XLEN-1 -: 32]);
        else if (op_q[1:0] == 0)  mul_res = lo_n;
        else if (neg_q)           mul_res = ~hi_n + XLEN'(lo_n == '0);
        else                      mul_res = hi_n;

        div_q   = neg_q ? -lo_n : lo_n;
        div_r   = neg_q ? -hi_n : hi_n;
        div_res = op_q[1] ? div_r : div_q;
        if (word_q) div_res = sext32(div_res[31:0]);

        final_res = spec_q ? spec_res_q : (op_q[2] ? div_res : mul_res);
    end

    // Datapath registers: loaded on accept, stepped while calculating
    always_ff @(posedge clock) begin
        // NOTE: datapath registers have no reset; they are always loaded on accept before use.
        if (accept) begin
            op_q       <= in_op;
            word_q     <= word_w;
            neg_q      <= neg_w;
            spec_q     <= special;
            spec_res_q <= special_res;
            hi         <= '0;
            lo         <= is_div ? dvd_load : mag2;
            opnd       <= is_div ? mag2 : mag1;
        end else if (state == CALC) begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

    // Control FSM with registered result handshake; flush and reset override everything
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        if (EARLY_OUT && special) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= special_res;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (last) begin
                        state      <= DONE;
                        cnt        <= '0;
                        out_valid  <= 1'b1;
                        out_result <= final_res;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter (XLEN=64, EARLY_OUT=1) with hand-computed results.
module tb_mdu_iter;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam int LF = 64;   // full-width latency in cycles after the accept edge
    localparam int LW = 32;   // word latency
    localparam int LE = 0;    // early-out latency

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_word, out_ready;
    logic        in_ready, out_valid;
    logic [2:0]  in_op;
    logic [63:0] in_src1, in_src2, out_result;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.XLEN(64), .EARLY_OUT(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one op at a point after a negedge; returns after the accept edge, at the next negedge
    task automatic issue(input string tag, input logic [2:0] op, input logic word,
                         input logic [63:0] s1, input logic [63:0] s2);
        in_op    = op;
        in_word  = word;
        in_src1  = s1;
        in_src2  = s2;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in_src1  = {$urandom, $urandom};
        in_src2  = {$urandom, $urandom};
        in_op    = 3'($urandom_range(0, 7));
        in_word  = 1'($urandom_range(0, 1));
    endtask

    // Count cycles until out_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                          input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(tag, op, word, s1, s2);
        wait_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, out_result, exp);
        consume();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  stable;
        bit  rose;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = 1'b0;
        out_ready = 1'b0; in_op = MUL; in_src1 = '0; in_src2 = '0;
        repeat (3) @(negedge clock);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", out_result, 64'd0);
        reset = 1'b0;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);

        // Multiply
        run_op("MUL -3*7", MUL, 0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, LF);
        run_op("MULH min*2", MULH, 0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LF);
        run_op("MULHU min*2", MULHU, 0, 64'h8000_0000_0000_0000, 64'd2, 64'h1, LF);
        run_op("MULHSU -1*max", MULHSU, 0, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, LF);
        run_op("MULH -5*3", MULH, 0, -64'sd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, LF);
        run_op("MULHU 2^32*2^32", MULHU, 0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, LF);
        run_op("MUL 2^32*2^32", MUL, 0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0, LF);
        run_op("MULW 7fffffff*2", MUL, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LW);
        run_op("MULH+word as MULW", MULH, 1, 64'h0000_0001_0000_0003, 64'hFFFF_0000_0000_0005, 64'hF, LW);

        // Divide boundaries
        run_op("DIVU by 0", DIVU, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LE);
        run_op("REMU by 0", REMU, 0, 64'h1234, 64'd0, 64'h1234, LE);
        run_op("DIV -1 by 0", DIV, 0, -64'sd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LE);
        run_op("REM -1 by 0", REM, 0, -64'sd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LE);
        run_op("DIV overflow", DIV, 0, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, LE);
        run_op("REM overflow", REM, 0, 64'h8000_0000_0000_0000, -64'sd1, 64'h0, LE);
        run_op("REMW overflow", REM, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, LE);
        run_op("DIVW overflow", DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LE);
        run_op("DIV min/2^32-1", DIV, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LF);
        run_op("DIVW by 0", DIV, 1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, LE);
        run_op("REMW by 0", REM, 1, 64'h8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, LE);

        // Divide normal
        run_op("DIVW -7/2", DIV, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LW);
        run_op("REM -7%2", REM, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LF);
        run_op("DIVU 100/7", DIVU, 0, 64'd100, 64'd7, 64'd14, LF);
        run_op("REMU 100%7", REMU, 0, 64'd100, 64'd7, 64'd2, LF);
        run_op("DIV -100/7", DIV, 0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, LF);
        run_op("REM -100%7", REM, 0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, LF);
        run_op("DIV 100/-7", DIV, 0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, LF);
        run_op("REM 100%-7", REM, 0, 64'd100, -64'sd7, 64'd2, LF);

        // Result held while out_ready is low
        issue("hold", MUL, 0, 64'd6, 64'd7);
        wait_valid(lat);
        check("hold latency", 64'(lat), 64'(LF));
        stable = 1'b1;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
            if (!out_valid || out_result !== 64'd42) stable = 1'b0;
        end
        check("hold stable", 64'(stable), 64'd1);
        check("hold result", out_result, 64'd42);
        consume();

        // Flush during CALC together with a new request: nothing accepted
        issue("flush calc", DIVU, 0, 64'd1000, 64'd3);
        repeat (5) @(negedge clock);
        flush = 1'b1; in_valid = 1'b1; in_op = MUL; in_word = 1'b0;
        in_src1 = 64'd3; in_src2 = 64'd3;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        rose = 1'b0;
        repeat (80) begin
            @(negedge clock);
            if (out_valid) rose = 1'b1;
        end
        check("flush no result", 64'(rose), 64'd0);

        // Back-to-back after flush
        run_op("after flush MUL", MUL, 0, 64'd3, 64'd3, 64'd9, LF);
        run_op("b2b DIVU", DIVU, 0, 64'd1000, 64'd3, 64'd333, LF);
        run_op("b2b REMUW", REMU, 1, 64'hDEAD_BEEF_0000_03E8, 64'd3, 64'd1, LW);

        // Flush in DONE discards the result even with out_ready high
        issue("flush done", MUL, 0, 64'd2, 64'd2);
        wait_valid(lat);
        check("flush done result", out_result, 64'd4);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("flush done out_valid", 64'(out_valid), 64'd0);
        check("flush done in_ready", 64'(in_ready), 64'd1);

        // Reset mid-op clears the result register
        issue("reset mid", MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("reset mid out_result", out_result, 64'd0);
        check("reset mid out_valid", 64'(out_valid), 64'd0);
        check("reset mid in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("reset mid ready after", 64'(in_ready), 64'd1);
        @(negedge clock);
        run_op("after reset MULHU", MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, LF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
